hamming_window_apply: RTL and testbench

Streaming windowing stage that multiplies each incoming real sample of a 512-point frame by its Hamming coefficient before the FFT. It reads coefficients from the shared constant table (cos/sin + Hamming window ROM) over that table's address/enable/data port, and unfolds the half-window (256 coefficients packed two per word) into the full 512-point symmetric window. It sits between the sample source and the FFT input, with valid/ready handshakes on both sides.

---
 rtl/hamming_window_apply.sv | 130 +++++++++++++
 tb/tb_hamming_window_apply.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_window_apply.sv
// rtl/hamming_window_apply.sv - Hamming window multiply stage between sample source and FFT
//
// Purpose: multiplies each real sample of a 512-point frame by its Hamming
// coefficient. The coefficient ROM stores only the first half of the window
// (256 entries, two per word); the second half is mirrored from the sample
// index. Three-stage pipeline (S0 lookup, S1 multiply, S2 output register)
// with one global advance so the external table register freezes with us.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_data/valid/last/ready  input sample stream
//   tab_a, tab_en, tab_q      constant table port (1-cycle registered read)
//   out_data/valid/last/ready windowed output stream
//   frame_err                 sticky: frame ended early by in_last

module hamming_window_apply #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [8:0]       tab_a,
    output logic             tab_en,
    input  logic [2*W+1:0]   tab_q,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             frame_err
);

    logic [8:0]   n_q, n_d;
    logic [8:0]   k;
    logic         advance;
    logic         accept;

    logic         s1_valid_q;
    logic [W-1:0] s1_data_q;
    logic         s1_sel_q;
    logic         s1_last_q;

    logic         out_valid_q;
    logic         out_last_q;
    logic [W-1:0] out_data_q;
    logic         frame_err_q;

    logic [W-1:0]          coef;
    logic signed [2*W+1:0] a_ext, c_ext, prod, rnd;
    logic signed [W+1:0]   scaled;
    logic [W-1:0]          sat_d;

    // A single advance stalls every stage, including the table's output
    // register, so the coefficient stays aligned with the S1 sample.
    assign advance = !out_valid_q || out_ready;
    assign accept  = in_valid && advance;

    // 511 - n equals the bitwise complement of a 9-bit n.
    assign k      = n_q[8] ? ~n_q : n_q;
    assign tab_a  = {2'b01, k[7:1]};
    assign tab_en = advance;
    assign in_ready = advance;

    always_comb begin
        n_d = n_q;
        if (accept) begin
            if (in_last || n_q == 9'd511) begin
                n_d = 9'd0;
            end else begin
                n_d = n_q + 9'd1;
            end
        end
    end

    // Coefficients are unsigned Q0.W; zero-extend so the product is signed.
    assign coef   = s1_sel_q ? tab_q[2*W:W+1] : tab_q[W-1:0];
    assign a_ext  = {{(W+2){s1_data_q[W-1]}}, s1_data_q};
    assign c_ext  = {{(W+2){1'b0}}, coef};
    assign prod   = a_ext * c_ext;
    assign rnd    = prod + {{(W+2){1'b0}}, 1'b1, {(W-1){1'b0}}};
    assign scaled = rnd[2*W+1:W];

    // In range only when the top three bits agree; otherwise clamp by sign.
    always_comb begin
        sat_d = scaled[W-1:0];
        if (scaled[W+1:W-1] != 3'b000 && scaled[W+1:W-1] != 3'b111) begin
            sat_d = scaled[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q         <= 9'd0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_sel_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            if (advance) begin
                n_q        <= n_d;
                s1_valid_q <= in_valid;
                s1_data_q  <= in_data;
                s1_sel_q   <= k[0];
                // Sample 511 closes the frame even without an explicit in_last.
                s1_last_q  <= in_valid && (in_last || n_q == 9'd511);

                out_valid_q <= s1_valid_q;
                out_last_q  <= s1_valid_q && s1_last_q;
                if (s1_valid_q) begin
                    out_data_q <= sat_d;
                end
            end
            if (accept && in_last && n_q != 9'd511) begin
                frame_err_q <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_hamming_window_apply.sv
// tb/tb_hamming_window_apply.sv - self-checking bench for hamming_window_apply

module tb_hamming_window_apply;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [8:0]    tab_a;
    logic          tab_en;
    logic [2*W+1:0] tab_q = '0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          frame_err;

    hamming_window_apply #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .tab_a(tab_a), .tab_en(tab_en), .tab_q(tab_q),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int coef [256];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mn = 0;
    int exp_d[$]; bit exp_l[$]; int exp_c[$];
    int got_d[$]; bit got_l[$]; int got_c[$];
    bit hold_v = 0;
    logic [W-1:0] hold_d;
    logic hold_l;

    // Constant table: half window, two coefficients per word, registered read.
    always @(posedge clk) begin
        if (tab_en) begin
            tab_q <= {1'b0, 16'(coef[{tab_a[6:0], 1'b1}]), 1'b0, 16'(coef[{tab_a[6:0], 1'b0}])};
        end
    end

    function automatic int model_win(int x, int n);
        int k;
        longint p, r;
        k = (n < 256) ? n : 511 - n;
        p = longint'(x) * longint'(coef[k]);
        r = (p + 64'sd32768) >>> 16;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic step(input bit v, input logic [W-1:0] d, input bit l, input bit r);
        int x;
        in_valid = v; in_data = d; in_last = l; out_ready = r;
        #1;
        if (hold_v) begin
            vectors++;
            if (out_data !== hold_d || out_last !== hold_l || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold: data=%h last=%b valid=%b, required data=%h last=%b valid=1",
                         out_data, out_last, out_valid, hold_d, hold_l);
            end
        end
        hold_v = out_valid && !r && !rst;
        hold_d = out_data;
        hold_l = out_last;
        if (out_valid && r) begin
            x = $signed(out_data);
            got_d.push_back(x); got_l.push_back(out_last); got_c.push_back(cyc);
        end
        if (v && in_ready) begin
            x = $signed(d);
            exp_d.push_back(model_win(x, mn));
            exp_l.push_back(l || mn == 511);
            exp_c.push_back(cyc);
            mn = l ? 0 : (mn + 1) % 512;
        end
        cyc++;
        @(negedge clk);
    endtask

    // kind: 0 = 7FFF, 1 = 8000, 2 = random; pv/pr are percent probabilities.
    task automatic send(input int count, input int kind, input int pv, input int pr);
        int start, guard;
        logic [W-1:0] d;
        start = exp_d.size();
        guard = 0;
        while (exp_d.size() - start < count && guard < 20000) begin
            d = (kind == 0) ? 16'h7FFF : (kind == 1) ? 16'h8000 : 16'($urandom);
            step($urandom_range(99) < pv, d, 1'b0, $urandom_range(99) < pr);
            guard++;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (got_d.size() < exp_d.size() && guard < 50) begin
            step(1'b0, '0, 1'b0, 1'b1);
            guard++;
        end
        if (got_d.size() != exp_d.size()) begin
            vectors++; miscompares++;
            $display("FAIL drain_count: got %0d outputs, required %0d", got_d.size(), exp_d.size());
        end
    endtask

    task automatic clear_q();
        exp_d.delete(); exp_l.delete(); exp_c.delete();
        got_d.delete(); got_l.delete(); got_c.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_last = 0; in_data = '0; out_ready = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 ||
            frame_err !== 1'b0 || tab_en !== 1'b1 || tab_a !== 9'h080) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%b ov=%b ol=%b od=%h fe=%b te=%b ta=%h, required 1 0 0 0000 0 1 080",
                     in_ready, out_valid, out_last, out_data, frame_err, tab_en, tab_a);
        end
        @(negedge clk);
        mn = 0;
    endtask

    task automatic test_full_max();
        int lasts = 0;
        clear_q();
        send(512, 0, 100, 100);
        drain();
        vectors++;
        if (got_c.size() > 0 && got_c[0] - exp_c[0] != 2) begin
            miscompares++; $display("FAIL latency: got %0d, required 2", got_c[0] - exp_c[0]);
        end
        if (got_d.size() == 512) begin
            vectors += 4;
            if (got_d[0] !== 2621)    begin miscompares++; $display("FAIL max_out0: got %0d, required 2621", got_d[0]); end
            if (got_d[255] !== 32767) begin miscompares++; $display("FAIL max_out255: got %0d, required 32767", got_d[255]); end
            if (got_d[256] !== 32767) begin miscompares++; $display("FAIL max_out256: got %0d, required 32767", got_d[256]); end
            if (got_d[511] !== 2621)  begin miscompares++; $display("FAIL max_out511: got %0d, required 2621", got_d[511]); end
            foreach (got_l[i]) if (got_l[i]) lasts++;
            vectors++;
            if (lasts != 1 || got_l[511] !== 1'b1) begin
                miscompares++; $display("FAIL max_last: %0d lasts, last511=%b, required 1 and 1", lasts, got_l[511]);
            end
        end
        vectors++;
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL max_frame_err: got %b, required 0", frame_err); end
    endtask

    task automatic test_full_min();
        int bad = 0;
        clear_q();
        send(512, 1, 100, 100);
        drain();
        foreach (got_d[i]) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL min_model[%0d]: got %0d/%b, required %0d/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        if (got_d.size() == 512) begin
            vectors++;
            if (got_d[255] !== -32767) begin miscompares++; $display("FAIL min_out255: got %0d, required -32767", got_d[255]); end
            for (int i = 0; i < 256; i++) if (got_d[i] !== got_d[511 - i]) bad++;
            vectors++;
            if (bad != 0) begin miscompares++; $display("FAIL min_symmetry: %0d asymmetric pairs, required 0", bad); end
        end
    endtask

    task automatic test_stall();
        clear_q();
        send(1536, 2, 70, 50);
        drain();
        foreach (got_d[i]) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL stall_model[%0d]: got %0d/%b, required %0d/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        send(1024, 2, 100, 100);
        drain();
        foreach (got_d[i]) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i] || got_l[i] !== (i % 512 == 511)) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got %0d/%b, required %0d/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_short_frame();
        clear_q();
        send(99, 0, 100, 100);
        vectors++;
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL short_pre_err: got %b, required 0", frame_err); end
        step(1'b1, 16'h7FFF, 1'b1, 1'b1);
        vectors++;
        if (frame_err !== 1'b1) begin miscompares++; $display("FAIL short_err_rise: got %b, required 1", frame_err); end
        drain();
        foreach (got_d[i]) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL short_model[%0d]: got %0d/%b, required %0d/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        vectors++;
        if (got_l.size() != 100 || got_l[99] !== 1'b1) begin
            miscompares++; $display("FAIL short_last99: %0d outputs, required 100 with last on 99", got_l.size());
        end
        clear_q();
        send(1, 0, 100, 100);
        drain();
        vectors++;
        if (got_d.size() != 1 || got_d[0] !== 2621) begin
            miscompares++; $display("FAIL short_restart: got %0d outputs first=%0d, required 2621", got_d.size(), got_d.size() ? got_d[0] : 0);
        end
        send(511, 2, 100, 100);
        drain();
        vectors++;
        if (frame_err !== 1'b1) begin miscompares++; $display("FAIL short_sticky: got %b, required 1", frame_err); end
    endtask

    task automatic test_rst_mid();
        clear_q();
        send(300, 2, 100, 100);
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || frame_err !== 1'b0 || tab_a !== 9'h080) begin
            miscompares++;
            $display("FAIL rst_mid_state: ov=%b fe=%b ta=%h, required 0 0 080", out_valid, frame_err, tab_a);
        end
        vectors++;
        if (got_d.size() != 298) begin
            miscompares++; $display("FAIL rst_mid_flushed: got %0d outputs, required 298", got_d.size());
        end
        clear_q();
        mn = 0;
        hold_v = 0;
        send(1, 0, 100, 100);
        drain();
        vectors++;
        if (got_d.size() != 1 || got_d[0] !== 2621) begin
            miscompares++; $display("FAIL rst_mid_restart: got %0d outputs first=%0d, required 2621", got_d.size(), got_d.size() ? got_d[0] : 0);
        end
    endtask

    initial begin
        real w;
        for (int k = 0; k < 256; k++) begin
            w = 0.54 - 0.46 * $cos(2.0 * 3.14159265358979 * k / 511.0);
            coef[k] = int'(w * 65536.0);
            if (coef[k] > 65535) coef[k] = 65535;
        end
        test_reset();
        test_full_max();
        test_full_min();
        test_stall();
        test_back_to_back();
        test_short_frame();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
